// File: rtl/processador_multiciclo_param.sv
// Parametrised multicycle processor: register/immediate instructions executed in
// micro-steps T0..T3 over a shared bus, with a Run/Done handshake to the source.
module processador_multiciclo_param #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned REG_ADDR_W = 3
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Run,
   input  logic [DATA_W-1:0]     DIN,
   input  logic [REG_ADDR_W-1:0] DbgSel,
   output logic [DATA_W-1:0]     DbgData,
   output logic                  Done,
   output logic [DATA_W-1:0]     BusWires,
   output logic [1:0]            Tstep,
   output logic                  Zflag
);

   localparam int unsigned IR_W = 3 + 2 * REG_ADDR_W;
   localparam int unsigned NREG = 1 << REG_ADDR_W;

   localparam logic [1:0] T0 = 2'd0;
   localparam logic [1:0] T1 = 2'd1;
   localparam logic [1:0] T2 = 2'd2;
   localparam logic [1:0] T3 = 2'd3;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_MVNZ = 3'b111;

   logic [1:0]            step_q, step_d;
   logic [IR_W-1:0]       ir_q;
   logic [DATA_W-1:0]     a_q;
   logic [DATA_W-1:0]     g_q;
   logic                  z_q;
   logic [DATA_W-1:0]     regs_q [NREG];

   logic [2:0]            op;
   logic [REG_ADDR_W-1:0] rx, ry, rsrc;
   logic                  src_reg, src_din, src_g;
   logic                  a_in, g_in, r_in;
   logic [DATA_W-1:0]     alu;

   assign op = ir_q[IR_W-1 -: 3];
   assign rx = ir_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
   assign ry = ir_q[REG_ADDR_W-1:0];

   always_comb begin
      step_d  = step_q;
      src_reg = 1'b0;
      src_din = 1'b0;
      src_g   = 1'b0;
      rsrc    = rx;
      a_in    = 1'b0;
      g_in    = 1'b0;
      r_in    = 1'b0;
      Done    = 1'b0;
      unique case (step_q)
         T0: if (Run) step_d = T1;
         T1: begin
            unique case (op)
               OP_MV: begin
                  src_reg = 1'b1; rsrc = ry; r_in = 1'b1; Done = 1'b1; step_d = T0;
               end
               OP_MVI: begin
                  src_din = 1'b1; r_in = 1'b1; Done = 1'b1; step_d = T0;
               end
               OP_MVNZ: begin
                  src_reg = 1'b1; rsrc = ry; r_in = !z_q; Done = 1'b1; step_d = T0;
               end
               default: begin
                  src_reg = 1'b1; rsrc = rx; a_in = 1'b1; step_d = T2;
               end
            endcase
         end
         T2: begin
            src_reg = 1'b1; rsrc = ry; g_in = 1'b1; step_d = T3;
         end
         T3: begin
            src_g = 1'b1; r_in = 1'b1; Done = 1'b1; step_d = T0;
         end
      endcase
   end

   // AND-OR bus: a double-enabled source shows up as corrupted data instead of being hidden
   assign BusWires = ({DATA_W{src_reg}} & regs_q[rsrc])
                   | ({DATA_W{src_din}} & DIN)
                   | ({DATA_W{src_g}}   & g_q);

   always_comb begin
      alu = '0;
      unique case (op)
         OP_ADD:  alu = a_q + BusWires;
         OP_SUB:  alu = a_q - BusWires;
         OP_AND:  alu = a_q & BusWires;
         OP_OR:   alu = a_q | BusWires;
         OP_SLT:  alu = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(BusWires))};
         default: alu = '0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         step_q <= T0;
         ir_q   <= '0;
         a_q    <= '0;
         g_q    <= '0;
         z_q    <= 1'b1;
         regs_q <= '{default: '0};
      end else begin
         step_q <= step_d;
         if (step_q == T0 && Run) ir_q <= DIN[IR_W-1:0];
         if (a_in) a_q <= BusWires;
         if (g_in) begin
            g_q <= alu;
            z_q <= (alu == '0);
         end
         if (r_in) regs_q[rx] <= BusWires;
      end
   end

   assign DbgData = regs_q[DbgSel];
   assign Tstep   = step_q;
   assign Zflag   = z_q;

endmodule
